branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ex_valid  in  1  an instruction is present in EX.
REQ-004 SHALL have ex_stall  in  1  EX is held this cycle.
REQ-005 SHALL have is_branch, is_jal, is_jalr  in  1 each  EX instruction class; at most one is high.
REQ-006 SHALL have funct3  in  3  branch condition code.
REQ-007 SHALL have br_eq, br_lt  in  1 each  from the signed comparator; br_ltu  in  1  from the unsigned comparator.
REQ-008 SHALL have pc, imm, rs1_data  in  32 each  EX operands.
REQ-009 SHALL have redirect_valid  out  1  and redirect_pc  out  32  to fetch.
REQ-010 SHALL have flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  squash controls.
REQ-011 SHALL have trap_misalign  out  1  and trap_pc  out  32  for a misaligned target.
REQ-012 SHALL have branch_cnt, taken_cnt  out  32 each  statistics.

Function
REQ-013 SHALL resolve only when state==IDLE, ex_valid=1 and ex_stall=0 ("resolve cycle").
REQ-014 SHALL decode funct3 as: 000 eq; 001 !eq; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 not taken.
REQ-015 SHALL treat jal and jalr as always taken.
REQ-016 SHALL compute the target as: branch/jal pc+imm; jalr (rs1_data+imm) & ~1; 32-bit wrap, no overflow flag.
REQ-017 SHALL flag a target misaligned when a taken target has target[1]=1.
REQ-018 SHALL, on a taken aligned resolve, register the target and move IDLE->REDIRECT at the next edge (1-cycle latency).
REQ-019 SHALL, in REDIRECT, assert redirect_valid=1, redirect_pc=target, and all three flushes, for exactly one cycle, then return to IDLE.
REQ-020 SHALL, in REDIRECT, ignore ex_valid and all branch inputs; the EX instruction is wrong-path and is not resolved.
REQ-021 SHALL give REDIRECT priority over ex_stall; stall does not extend REDIRECT.
REQ-022 SHALL, on a taken misaligned resolve, pulse trap_misalign=1 with trap_pc=pc for one cycle next cycle, not redirect, and stay in IDLE.
REQ-023 SHALL, on a not-taken resolve, produce no output activity and stay in IDLE.
REQ-024 SHALL drive redirect_valid, flushes and trap_misalign to 0 whenever they are not pulsed; redirect_pc and trap_pc hold their last value.
REQ-025 SHALL, when resolving back-to-back taken branches, resolve the second only after REDIRECT completes.

Reset
REQ-026 SHALL, on rst, immediately enter IDLE and drive redirect_valid, all flushes and trap_misalign to 0, with redirect_pc, trap_pc and both counters at 0.
REQ-027 SHALL drop an in-flight REDIRECT or trap pulse when rst asserts mid-pulse, and not replay it after reset.

Configuration
REQ-028 SHALL include the statistics counters only with BRU_STATS_EN defined.
REQ-029 SHALL, with BRU_STATS_EN, increment branch_cnt on each resolve with is_branch=1 and taken_cnt on each taken one, both saturating at 0xFFFFFFFF.
REQ-030 SHALL, without BRU_STATS_EN, keep the same ports and tie both counters to 0.

Structure
REQ-031 SHALL place the funct3 condition constants and the state enum (IDLE, REDIRECT) in shared package brc_pkg.
REQ-032 SHALL put the combinational taken decision (REQ-014/015) in sub-module branch_cond.

Verification
REQ-033 Bench SHALL cover: BEQ, br_eq=1, pc=0x100, imm=0x20 -> next cycle redirect_valid=1, redirect_pc=0x120, all flushes=1 for one cycle.
REQ-034 Bench SHALL cover: BLT, br_lt=0 -> no redirect, no flush, state stays IDLE.
REQ-035 Bench SHALL cover: JALR, rs1_data=0x203, imm=0 -> redirect_pc=0x202, trap_misalign=1, trap_pc=pc, no redirect.
REQ-036 Bench SHALL cover: taken BNE with ex_stall=1 -> no action; the same instruction with stall released -> redirect; a taken BEQ in EX during REDIRECT -> ignored.
REQ-037 Bench SHALL cover: rst asserted during REDIRECT -> redirect_valid=0 immediately, with no pulse after reset releases.
REQ-038 Bench SHALL cover, with BRU_STATS_EN: 3 BEQ (2 taken) plus 1 JAL -> branch_cnt=3, taken_cnt=2.

Source files
------------

// File: rtl/brc_pkg.sv
// Shared definitions for the branch resolve unit: funct3 condition codes
// and controller state. Optional feature macro: BRU_STATS_EN.
package brc_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   typedef enum logic {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } brc_state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == CNT_MAX) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational taken decision for the EX instruction.
// Jumps are always taken; branches follow the funct3 condition.
module branch_cond
   import brc_pkg::*;
(
   input  logic       is_branch,
   input  logic       is_jal,
   input  logic       is_jalr,
   input  logic [2:0] funct3,
   input  logic       br_eq,
   input  logic       br_lt,
   input  logic       br_ltu,
   output logic       taken
);

   logic cond;

   always_comb begin
      cond = 1'b0;
      case (funct3)
         F3_BEQ:  cond = br_eq;
         F3_BNE:  cond = ~br_eq;
         F3_BLT:  cond = br_lt;
         F3_BGE:  cond = ~br_lt;
         F3_BLTU: cond = br_ltu;
         F3_BGEU: cond = ~br_ltu;
         default: cond = 1'b0;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      unique case (1'b1)
         is_jal:    taken = 1'b1;
         is_jalr:   taken = 1'b1;
         is_branch: taken = cond;
         default:   taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX control transfers into a one-cycle redirect/flush pulse or a
// misalignment trap. Statistics counters present only with BRU_STATS_EN.
module branch_resolve_unit
   import brc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_stall,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic [2:0]  funct3,
   input  logic        br_eq,
   input  logic        br_lt,
   input  logic        br_ltu,
   input  logic [31:0] pc,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        flush_ex_mem,
   output logic        trap_misalign,
   output logic [31:0] trap_pc,
   output logic [31:0] branch_cnt,
   output logic [31:0] taken_cnt
);

   brc_state_e  state_q, state_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        trap_misalign_q, trap_misalign_d;
   logic [31:0] trap_pc_q, trap_pc_d;

   logic        taken;
   logic        resolve;
   logic [31:0] target;

   branch_cond u_cond (
      .is_branch (is_branch),
      .is_jal    (is_jal),
      .is_jalr   (is_jalr),
      .funct3    (funct3),
      .br_eq     (br_eq),
      .br_lt     (br_lt),
      .br_ltu    (br_ltu),
      .taken     (taken)
   );

   assign resolve = (state_q == IDLE) & ex_valid & ~ex_stall;

   always_comb begin
      target = pc + imm;
      if (is_jalr) begin
         target = (rs1_data + imm) & ~32'd1;
      end
   end

   // Target is captured on every taken resolve, so a trapped jump still
   // leaves its computed target visible on redirect_pc.
   always_comb begin
      state_d          = IDLE;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      trap_misalign_d  = 1'b0;
      trap_pc_d        = trap_pc_q;
      if (resolve && taken) begin
         redirect_pc_d = target;
         if (target[1]) begin
            trap_misalign_d = 1'b1;
            trap_pc_d       = pc;
         end else begin
            state_d          = REDIRECT;
            redirect_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= 32'd0;
         trap_misalign_q  <= 1'b0;
         trap_pc_q        <= 32'd0;
      end else begin
         state_q          <= state_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         trap_misalign_q  <= trap_misalign_d;
         trap_pc_q        <= trap_pc_d;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign flush_if_id    = redirect_valid_q;
   assign flush_id_ex    = redirect_valid_q;
   assign flush_ex_mem   = redirect_valid_q;
   assign trap_misalign  = trap_misalign_q;
   assign trap_pc        = trap_pc_q;

`ifdef BRU_STATS_EN
   logic [31:0] branch_cnt_q, branch_cnt_d;
   logic [31:0] taken_cnt_q, taken_cnt_d;

   always_comb begin
      branch_cnt_d = branch_cnt_q;
      taken_cnt_d  = taken_cnt_q;
      if (resolve && is_branch) begin
         branch_cnt_d = sat_inc(branch_cnt_q);
         if (taken) begin
            taken_cnt_d = sat_inc(taken_cnt_q);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt_q <= 32'd0;
         taken_cnt_q  <= 32'd0;
      end else begin
         branch_cnt_q <= branch_cnt_d;
         taken_cnt_q  <= taken_cnt_d;
      end
   end

   assign branch_cnt = branch_cnt_q;
   assign taken_cnt  = taken_cnt_q;
`else
   assign branch_cnt = 32'd0;
   assign taken_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed cases plus random traffic
// checked every cycle against a behavioural model.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0, ex_stall = 1'b0;
   logic        is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
   logic [2:0]  funct3 = 3'b0;
   logic        br_eq = 1'b0, br_lt = 1'b0, br_ltu = 1'b0;
   logic [31:0] pc = '0, imm = '0, rs1_data = '0;
   logic        redirect_valid, flush_if_id, flush_id_ex, flush_ex_mem;
   logic        trap_misalign;
   logic [31:0] redirect_pc, trap_pc, branch_cnt, taken_cnt;

   int checks = 0;
   int errors = 0;

   branch_resolve_unit dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
      .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
      .funct3(funct3), .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
      .pc(pc), .imm(imm), .rs1_data(rs1_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .flush_ex_mem(flush_ex_mem), .trap_misalign(trap_misalign),
      .trap_pc(trap_pc), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural model: outputs expected after each rising edge.
   logic        m_rv = 1'b0, m_tm = 1'b0;
   logic [31:0] m_rpc = '0, m_tpc = '0, m_bc = '0, m_tc = '0;

   function automatic logic m_taken();
      if (is_jal || is_jalr) return 1'b1;
      if (!is_branch) return 1'b0;
      case (funct3)
         3'd0: return br_eq;
         3'd1: return !br_eq;
         3'd4: return br_lt;
         3'd5: return !br_lt;
         3'd6: return br_ltu;
         3'd7: return !br_ltu;
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rv = 0; m_tm = 0; m_rpc = 0; m_tpc = 0; m_bc = 0; m_tc = 0;
      end else begin
         logic        busy, res, tk;
         logic [31:0] tgt;
         busy = m_rv;
         res  = !busy && ex_valid && !ex_stall;
         tk   = m_taken();
         tgt  = is_jalr ? ((rs1_data + imm) & 32'hFFFF_FFFE) : (pc + imm);
         m_rv = 0;
         m_tm = 0;
         if (res && tk) begin
            m_rpc = tgt;
            if (tgt[1]) begin m_tm = 1; m_tpc = pc; end
            else m_rv = 1;
         end
`ifdef BRU_STATS_EN
         if (res && is_branch) begin
            if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
            if (tk && m_tc != 32'hFFFF_FFFF) m_tc = m_tc + 1;
         end
`endif
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("cmp_rv", 32'(redirect_valid), 32'(m_rv));
         chk("cmp_flush", {29'd0, flush_if_id, flush_id_ex, flush_ex_mem},
             {29'd0, {3{m_rv}}});
         chk("cmp_rpc", redirect_pc, m_rpc);
         chk("cmp_tm", 32'(trap_misalign), 32'(m_tm));
         chk("cmp_tpc", trap_pc, m_tpc);
         chk("cmp_bcnt", branch_cnt, m_bc);
         chk("cmp_tcnt", taken_cnt, m_tc);
      end
   end

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      ex_valid = 0; ex_stall = 0;
      is_branch = 0; is_jal = 0; is_jalr = 0;
   endtask

   task automatic br(input logic [2:0] f3, input logic eq, input logic lt,
                     input logic [31:0] p, input logic [31:0] i);
      idle();
      ex_valid = 1; is_branch = 1; funct3 = f3;
      br_eq = eq; br_lt = lt; br_ltu = 0; pc = p; imm = i;
   endtask

   initial begin
      idle();
      cycle();
      cycle();
      rst = 0;
      cycle();
      chk("reset_rv", 32'(redirect_valid), 32'd0);
      chk("reset_rpc", redirect_pc, 32'd0);
      chk("reset_cnt", branch_cnt, 32'd0);

      // BEQ taken: pc 0x100 + 0x20
      br(3'd0, 1, 0, 32'h100, 32'h20);
      cycle();
      idle();
      chk("beq_rv", 32'(redirect_valid), 32'd1);
      chk("beq_rpc", redirect_pc, 32'h120);
      chk("beq_flush", {29'd0, flush_if_id, flush_id_ex, flush_ex_mem},
          32'd7);
      cycle();
      chk("beq_one_cycle", 32'(redirect_valid), 32'd0);

      // BLT not taken
      br(3'd4, 0, 0, 32'h200, 32'h40);
      cycle();
      idle();
      chk("blt_nt_rv", 32'(redirect_valid), 32'd0);
      chk("blt_nt_flush", 32'(flush_id_ex), 32'd0);

      // JALR to 0x202: misaligned -> trap
      idle();
      ex_valid = 1; is_jalr = 1; rs1_data = 32'h203; imm = 0;
      pc = 32'h300;
      cycle();
      idle();
      chk("jalr_tm", 32'(trap_misalign), 32'd1);
      chk("jalr_tpc", trap_pc, 32'h300);
      chk("jalr_rpc", redirect_pc, 32'h202);
      chk("jalr_no_rv", 32'(redirect_valid), 32'd0);
      cycle();
      chk("jalr_tm_drop", 32'(trap_misalign), 32'd0);

      // Stalled BNE, then released, then BEQ during REDIRECT
      br(3'd1, 0, 0, 32'h400, 32'h10);
      ex_stall = 1;
      cycle();
      chk("stall_no_rv", 32'(redirect_valid), 32'd0);
      ex_stall = 0;
      cycle();
      chk("unstall_rv", 32'(redirect_valid), 32'd1);
      chk("unstall_rpc", redirect_pc, 32'h410);
      br(3'd0, 1, 0, 32'h500, 32'h8);
      ex_stall = 1;
      cycle();
      idle();
      chk("redir_ignore", 32'(redirect_valid), 32'd0);
      chk("redir_ignore_pc", redirect_pc, 32'h410);

      // Reset mid-REDIRECT
      br(3'd0, 1, 0, 32'h600, 32'h4);
      cycle();
      idle();
      chk("pre_rst_rv", 32'(redirect_valid), 32'd1);
      rst = 1;
      #1;
      chk("rst_rv_now", 32'(redirect_valid), 32'd0);
      chk("rst_flush_now", 32'(flush_if_id), 32'd0);
      chk("rst_rpc_now", redirect_pc, 32'd0);
      cycle();
      rst = 0;
      cycle();
      chk("post_rst_rv", 32'(redirect_valid), 32'd0);
      cycle();
      chk("post_rst_rv2", 32'(redirect_valid), 32'd0);

      // Statistics: 3 BEQ (2 taken) + 1 JAL
      br(3'd0, 1, 0, 32'h700, 32'h8);  cycle(); idle(); cycle();
      br(3'd0, 0, 0, 32'h710, 32'h8);  cycle(); idle(); cycle();
      br(3'd0, 1, 0, 32'h720, 32'h8);  cycle(); idle(); cycle();
      idle(); ex_valid = 1; is_jal = 1; pc = 32'h730; imm = 32'h100;
      cycle(); idle(); cycle();
`ifdef BRU_STATS_EN
      chk("stat_bcnt", branch_cnt, 32'd3);
      chk("stat_tcnt", taken_cnt, 32'd2);
`else
      chk("stat_bcnt_off", branch_cnt, 32'd0);
      chk("stat_tcnt_off", taken_cnt, 32'd0);
`endif

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         int k;
         idle();
         ex_valid = ($urandom_range(0, 9) < 7);
         ex_stall = ($urandom_range(0, 9) < 2);
         k = $urandom_range(0, 5);
         is_branch = (k <= 2);
         is_jal    = (k == 3);
         is_jalr   = (k == 4);
         funct3 = 3'($urandom);
         br_eq = 1'($urandom); br_lt = 1'($urandom); br_ltu = 1'($urandom);
         pc = $urandom & 32'hFFFF_FFFC;
         imm = ($urandom_range(0, 3) == 0) ? $urandom
             : 32'($signed(12'($urandom)));
         rs1_data = $urandom;
         rst = ($urandom_range(0, 199) == 0);
         cycle();
      end
      rst = 0;
      idle();
      cycle();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
